// File: rtl/wb_regfile_if.sv
// Bundle between the MEM stage / decode side and the write-back register bank.
// Only the clock and reset are kept outside it.
interface wb_regfile_if;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_ld_type;
    logic        mem_is_link;
    logic [31:0] mem_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output stall, flush, mem_valid, mem_reg_we, mem_rd, mem_alu_res,
               mem_load_data, mem_ld_type, mem_is_link, mem_pc, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_we, mem_rd, mem_alu_res,
               mem_load_data, mem_ld_type, mem_is_link, mem_pc, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/wb_regfile.sv
// DLX write-back stage: MEM/WB latch, load formatting, result select and the
// 32x32 integer register bank with write-through read ports.
module wb_regfile #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int LINK_REG = 31
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);

    logic          valid_q;
    logic          we_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] ld_q;
    logic [2:0]    type_q;
    logic          link_q;
    logic [DW-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            ld_q    <= '0;
            type_q  <= '0;
            link_q  <= 1'b0;
            pc_q    <= '0;
        end else if (bus.stall) begin
            valid_q <= valid_q;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= bus.mem_valid;
            we_q    <= bus.mem_reg_we;
            rd_q    <= bus.mem_rd;
            alu_q   <= bus.mem_alu_res;
            ld_q    <= bus.mem_load_data;
            type_q  <= bus.mem_ld_type;
            link_q  <= bus.mem_is_link;
            pc_q    <= bus.mem_pc;
        end
    end

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_fmt;

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    always_comb begin
        ld_byte = ld_q[7:0];
        case (alu_q[1:0])
            2'd0:    ld_byte = ld_q[31:24];
            2'd1:    ld_byte = ld_q[23:16];
            2'd2:    ld_byte = ld_q[15:8];
            default: ld_byte = ld_q[7:0];
        endcase
        ld_half = alu_q[1] ? ld_q[15:0] : ld_q[31:16];
        ld_fmt  = ld_q;
        case (type_q)
            3'b001:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_fmt = {24'd0, ld_byte};
            3'b011:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = ld_q;
        endcase
    end

    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;

    always_comb begin
        wb_rd   = link_q ? 5'(LINK_REG) : rd_q;
        wb_we   = valid_q & we_q & (wb_rd != 5'd0);
        wb_data = alu_q;
        if (link_q) begin
            wb_data = pc_q + DW'(4);
        end else if (type_q != 3'b000) begin
            wb_data = ld_fmt;
        end
    end

    logic [DW-1:0] bank [NREG];

    // A stalled write simply repeats the same value; r0 is excluded by wb_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else if (wb_we) begin
            bank[wb_rd] <= wb_data;
        end
    end

    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (bus.rs1_addr != 5'd0) begin
            rs1_val = (wb_we && wb_rd == bus.rs1_addr) ? wb_data : bank[bus.rs1_addr];
        end
        if (bus.rs2_addr != 5'd0) begin
            rs2_val = (wb_we && wb_rd == bus.rs2_addr) ? wb_data : bank[bus.rs2_addr];
        end
    end

    assign bus.rs1_data = rs1_val;
    assign bus.rs2_data = rs2_val;
    assign bus.wb_we    = wb_we;
    assign bus.wb_rd    = wb_rd;
    assign bus.wb_data  = wb_data;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural integer register bank for the 5-stage DLX pipeline.
- Latches MEM-stage results into the MEM/WB register, formats load data, selects ALU, load or link result, and writes the 32x32 register bank.
- Bank contents feed the two 32-to-1 operand read multiplexers on the decode side.
- The read ports are exposed here with write-through bypass, so decode sees a same-cycle write-back.

Parameters:
- DW, 32, data width; fixed at 32 for the DLX datapath.
- NREG, 32, number of registers; register index width is 5.
- LINK_REG, 31, destination forced for link (JAL/JALR) results.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold the MEM/WB latch
- flush  input  1  load a bubble into the MEM/WB latch
- mem_valid  input  1  MEM stage holds a real instruction
- mem_reg_we  input  1  instruction writes a register
- mem_rd  input  5  destination register
- mem_alu_res  input  32  ALU result or effective address
- mem_load_data  input  32  raw word from data memory
- mem_ld_type  input  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW
- mem_is_link  input  1  JAL/JALR
- mem_pc  input  32  PC of the instruction
- rs1_addr  input  5  read port 1 index
- rs2_addr  input  5  read port 2 index
- rs1_data  output  32  read port 1 data
- rs2_data  output  32  read port 2 data
- wb_we  output  1  write enable currently applied (for hazard/forward logic)
- wb_rd  output  5  destination currently being written
- wb_data  output  32  value currently being written

Behaviour:
- MEM/WB latch, updated on the rising clk edge:
  - rst=1: latch valid=0, all fields 0.
  - Else stall=1: hold. Stall has priority over flush.
  - Else flush=1: valid=0, we=0, other fields don't-care.
  - Else: capture all mem_* inputs.
- Write enable, combinational from the latch: wb_we = valid & reg_we & (dest != 0).
- Destination: wb_rd = LINK_REG when is_link, else the latched rd.
- Result select: link gives pc+4 (mod 2^32); ld_type!=000 gives formatted load; otherwise alu_res.
- Load formatting (big-endian; a = latched alu_res[1:0]):
  - Byte lane: a=0 gives bits[31:24], a=1 bits[23:16], a=2 bits[15:8], a=3 bits[7:0].
  - LB sign-extends the byte; LBU zero-extends it.
  - Halfword: a[1]=0 gives bits[31:16], a[1]=1 gives bits[15:0]; a[0] is ignored (no trap).
  - LH sign-extends the halfword; LHU zero-extends it.
  - LW ignores a.
  - ld_type 110/111 is treated as LW.
- Register bank:
  - 32 x 32 flops; register 0 always reads 0 and is never written.
  - Write occurs at the rising edge ending the WB cycle when wb_we=1.
  - During stall the write repeats with the same value, which is idempotent.
  - rst=1 clears all registers to 0 and suppresses the write in that cycle.
- Read ports, combinational, no latency:
  - Index 0 returns 0.
  - Else, if wb_we=1 and wb_rd equals the index, return wb_data (bypass).
  - Else return the bank entry.
  - Both ports are independent and may address the same register.
- Reset values: rs1_data=rs2_data=0, wb_we=0, wb_rd=0, wb_data=0.
- Latency: an instruction presented at edge N is visible on wb_* during cycle N+1 and committed to the bank at edge N+1.
- Mid-operation reset: an in-flight write is discarded.

Test Plan:
- ALU write: rd=5, alu_res=0x12345678, ld_type=000, valid=1 -> next cycle wb_we=1, wb_rd=5; rs1_addr=5 reads 0x12345678 both before (bypass) and after the commit edge.
- Loads: load_data=0x80FF7F01:
  - LB a=0 -> 0xFFFFFF80; LBU a=0 -> 0x00000080.
  - LH a=2 -> 0x00007F01; LHU a=0 -> 0x000080FF; LW -> 0x80FF7F01.
- Link: is_link=1, pc=0x00000100, rd=7 -> wb_rd=31, wb_data=0x00000104, r7 unchanged.
- r0 protection: rd=0, we=1, alu_res=0xDEADBEEF -> wb_we=0 and rs1_addr=0 returns 0.
- Stall and flush:
  - stall=1 for 3 cycles holds wb_* constant.
  - stall=1 and flush=1 together -> hold.
  - flush=1 alone -> wb_we=0 next cycle and no bank change.
- Reset: load r1..r31 with nonzero values, then rst=1 for one cycle -> every read returns 0 and wb_we=0; a write pending in the latch at reset is lost.
